// File: rtl/tla_cap_ctrl_50.sv
// Capture controller in the Ga_clk50 domain: hold-off delay, buffer write
// sequencing and the ready/complete handshake toward the control side.
module tla_cap_ctrl_50 #(
    parameter int TOP0_0  = 3,
    parameter int LDD0_0  = 32,
    parameter int ADC0_2  = 2,
    parameter int DEPTH_W = 12
) (
    input  logic               Ga_clk50,
    input  logic               Ga_rst_n,
    input  logic               Ga_cap_trig,
    input  logic               Ga_cap_cmpt,
    input  logic [ADC0_2-1:0]  Ga_cap_phase,
    input  logic               Ga_cap_mode,
    input  logic [TOP0_0-1:0]  Ga_cap_wdis,
    input  logic [LDD0_0-1:0]  Ga_cap_plus,
    output logic               Ga_capr_rdy,
    output logic               cap_wr_en,
    output logic [DEPTH_W-1:0] cap_wr_addr,
    output logic [ADC0_2-1:0]  cap_phase_q,
    output logic               cap_busy,
    output logic               cap_ovf,
    output logic               cap_trig_miss
);

    typedef enum logic [1:0] {IDLE, HOLD, CAPT, DONE} state_t;

    localparam int unsigned DEPTH_I = 1 << DEPTH_W;
    localparam logic [LDD0_0-1:0] DEPTH = LDD0_0'(DEPTH_I);

    state_t             state_q;
    logic               trig_q, cmpt_q, mode_q;
    logic [LDD0_0-1:0]  hold_q, hcnt_q;
    logic [DEPTH_W-1:0] last_q, cnt_q;
    logic               rdy_q, wr_en_q, busy_q, ovf_q, miss_q;
    logic [DEPTH_W-1:0] addr_q;
    logic [ADC0_2-1:0]  phase_q;

    logic               trig_edge, cmpt_edge, ovf_d;
    logic [LDD0_0-1:0]  hold_d;
    logic [DEPTH_W-1:0] last_d;

    assign trig_edge = Ga_cap_trig & ~trig_q;
    assign cmpt_edge = Ga_cap_cmpt & ~cmpt_q;

    // Length is stored as the last address; zero still yields one write.
    always_comb begin
        hold_d = (LDD0_0'(1) << Ga_cap_wdis) - LDD0_0'(1)
               + LDD0_0'(Ga_cap_phase);
        ovf_d  = Ga_cap_plus > DEPTH;
        last_d = DEPTH_W'(Ga_cap_plus - LDD0_0'(1));
        if (Ga_cap_plus == '0)
            last_d = '0;
        else if (Ga_cap_plus >= DEPTH)
            last_d = '1;
    end

    always_ff @(posedge Ga_clk50 or negedge Ga_rst_n) begin
        if (!Ga_rst_n) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
            cmpt_q  <= 1'b0;
            mode_q  <= 1'b0;
            hold_q  <= '0;
            hcnt_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            miss_q  <= 1'b0;
            addr_q  <= '0;
            phase_q <= '0;
        end else begin
            trig_q  <= Ga_cap_trig;
            cmpt_q  <= Ga_cap_cmpt;
            wr_en_q <= (state_q == CAPT);
            addr_q  <= (state_q == CAPT) ? cnt_q : '0;
            busy_q  <= (state_q == HOLD) || (state_q == CAPT);
            rdy_q   <= (state_q == DONE) && !cmpt_edge;
            if (trig_edge && state_q != IDLE)
                miss_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (trig_edge) begin
                        phase_q <= Ga_cap_phase;
                        last_q  <= last_d;
                        ovf_q   <= ovf_d;
                        hold_q  <= hold_d;
                        hcnt_q  <= hold_d;
                        mode_q  <= Ga_cap_mode;
                        miss_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= (hold_d != '0) ? HOLD : CAPT;
                    end
                end
                HOLD: begin
                    hcnt_q <= hcnt_q - LDD0_0'(1);
                    if (hcnt_q == LDD0_0'(1))
                        state_q <= CAPT;
                end
                CAPT: begin
                    if (cnt_q == last_q) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + DEPTH_W'(1);
                    end
                end
                DONE: begin
                    // Re-arm only while continuous mode is still requested.
                    if (cmpt_edge) begin
                        mode_q <= Ga_cap_mode;
                        if (mode_q && Ga_cap_mode) begin
                            hcnt_q  <= hold_q;
                            cnt_q   <= '0;
                            state_q <= (hold_q != '0) ? HOLD : CAPT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Ga_capr_rdy   = rdy_q;
    assign cap_wr_en     = wr_en_q;
    assign cap_wr_addr   = addr_q;
    assign cap_phase_q   = phase_q;
    assign cap_busy      = busy_q;
    assign cap_ovf       = ovf_q;
    assign cap_trig_miss = miss_q;

endmodule

// File: tb/tb_tla_cap_ctrl_50.sv
// Directed bench for tla_cap_ctrl_50: timing of writes, hold-off,
// length clamp, continuous re-arm, trigger miss and async reset.
module tb_tla_cap_ctrl_50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig, cmpt, mode;
    logic [1:0]  phase;
    logic [2:0]  wdis;
    logic [31:0] plus;
    logic        rdy, wr_en, busy, ovf, miss;
    logic [11:0] addr;
    logic [1:0]  phase_o;

    int checks = 0;
    int failures = 0;

    tla_cap_ctrl_50 dut (
        .Ga_clk50      (clk),
        .Ga_rst_n      (rst_n),
        .Ga_cap_trig   (trig),
        .Ga_cap_cmpt   (cmpt),
        .Ga_cap_phase  (phase),
        .Ga_cap_mode   (mode),
        .Ga_cap_wdis   (wdis),
        .Ga_cap_plus   (plus),
        .Ga_capr_rdy   (rdy),
        .cap_wr_en     (wr_en),
        .cap_wr_addr   (addr),
        .cap_phase_q   (phase_o),
        .cap_busy      (busy),
        .cap_ovf       (ovf),
        .cap_trig_miss (miss)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; trig = 0; cmpt = 0; mode = 0;
        phase = 0; wdis = 0; plus = 0;
        tick(3);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_miss", 32'(miss), 0);
        chk("rst_phase", 32'(phase_o), 0);
        rst_n = 1'b1;
        tick(2);

        // basic capture, hold = 0, length 4
        plus = 4; trig = 1;
        tick(1);
        chk("t1_c1_wr", 32'(wr_en), 0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("t1_wr", 32'(wr_en), 1);
            chk("t1_addr", 32'(addr), 32'(i));
            if (i == 1) chk("t1_busy", 32'(busy), 1);
        end
        tick(1);
        chk("t1_c6_wr", 32'(wr_en), 0);
        chk("t1_c6_rdy", 32'(rdy), 1);
        chk("t1_c6_addr", 32'(addr), 0);
        chk("t1_c6_busy", 32'(busy), 0);
        tick(4);
        chk("t1_c10_rdy", 32'(rdy), 1);
        cmpt = 1;
        tick(1);
        chk("t1_c11_rdy", 32'(rdy), 0);
        tick(3);
        chk("t1_held_wr", 32'(wr_en), 0);
        chk("t1_held_busy", 32'(busy), 0);
        trig = 0; cmpt = 0;
        tick(2);

        // hold-off of 9 cycles, single sample
        wdis = 3; phase = 2; plus = 1; trig = 1;
        tick(5);
        chk("t2_busy_hold", 32'(busy), 1);
        tick(5);
        chk("t2_c10_wr", 32'(wr_en), 0);
        tick(1);
        chk("t2_c11_wr", 32'(wr_en), 1);
        chk("t2_c11_addr", 32'(addr), 0);
        chk("t2_phase", 32'(phase_o), 2);
        chk("t2_ovf", 32'(ovf), 0);
        tick(1);
        chk("t2_c12_wr", 32'(wr_en), 0);
        tick(1);
        chk("t2_c13_rdy", 32'(rdy), 1);
        cmpt = 1;
        tick(1);
        chk("t2_c14_rdy", 32'(rdy), 0);
        trig = 0; cmpt = 0; wdis = 0; phase = 0;
        tick(2);

        // length clamp to 4096 with overflow flag
        plus = 5000; trig = 1;
        tick(1);
        chk("t3_ovf", 32'(ovf), 1);
        for (int i = 0; i < 4096; i++) begin
            tick(1);
            chk("t3_addr", 32'(addr), 32'(i));
        end
        chk("t3_last_wr", 32'(wr_en), 1);
        tick(1);
        chk("t3_end_wr", 32'(wr_en), 0);
        chk("t3_end_addr", 32'(addr), 0);
        chk("t3_end_rdy", 32'(rdy), 1);
        cmpt = 1;
        tick(1);
        trig = 0; cmpt = 0;
        tick(2);

        // zero length means a single write
        plus = 0; trig = 1;
        tick(2);
        chk("t3z_wr", 32'(wr_en), 1);
        chk("t3z_addr", 32'(addr), 0);
        chk("t3z_ovf", 32'(ovf), 0);
        tick(1);
        chk("t3z_wr_off", 32'(wr_en), 0);
        tick(1);
        chk("t3z_rdy", 32'(rdy), 1);
        cmpt = 1;
        tick(1);
        trig = 0; cmpt = 0;
        tick(2);

        // continuous mode, re-arm, miss, then leave
        mode = 1; plus = 3; trig = 1;
        tick(1);
        trig = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t4_addr_a", 32'(addr), 32'(i));
        end
        tick(1);
        chk("t4_c5_rdy", 32'(rdy), 1);
        tick(1);
        cmpt = 1;
        tick(1);
        chk("t4_c7_rdy", 32'(rdy), 0);
        cmpt = 0;
        tick(1);
        chk("t4_c8_wr", 32'(wr_en), 1);
        chk("t4_c8_addr", 32'(addr), 0);
        trig = 1;
        tick(1);
        trig = 0;
        chk("t4_miss", 32'(miss), 1);
        chk("t4_c9_addr", 32'(addr), 1);
        tick(1);
        chk("t4_c10_addr", 32'(addr), 2);
        chk("t4_c10_wr", 32'(wr_en), 1);
        tick(1);
        chk("t4_c11_rdy", 32'(rdy), 1);
        chk("t4_c11_wr", 32'(wr_en), 0);
        mode = 0;
        tick(1);
        cmpt = 1;
        tick(1);
        chk("t4_c13_rdy", 32'(rdy), 0);
        tick(2);
        chk("t4_idle_wr", 32'(wr_en), 0);
        chk("t4_idle_busy", 32'(busy), 0);
        chk("t4_miss_sticky", 32'(miss), 1);
        cmpt = 0;
        tick(2);

        // asynchronous reset mid-capture
        plus = 20; trig = 1;
        tick(9);
        chk("t5_addr7", 32'(addr), 7);
        rst_n = 0; trig = 0;
        #1;
        chk("t5_rst_wr", 32'(wr_en), 0);
        chk("t5_rst_addr", 32'(addr), 0);
        chk("t5_rst_rdy", 32'(rdy), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_miss", 32'(miss), 0);
        tick(2);
        rst_n = 1;
        tick(2);
        plus = 2; trig = 1;
        tick(2);
        chk("t5_new_a0", 32'(addr), 0);
        chk("t5_new_wr", 32'(wr_en), 1);
        tick(1);
        chk("t5_new_a1", 32'(addr), 1);
        tick(1);
        chk("t5_new_rdy", 32'(rdy), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
